// File: rtl/dly_sched_pkg.sv
// Shared types and helpers for the delay scheduler: entry layout, delay
// clamping and the wrap-safe "due time reached" comparison.
package dly_sched_pkg;

   // Default sample and time widths; the modules' parameters must keep these.
   localparam int SAMP_W = 2;
   localparam int TIME_W = 8;

   // Largest delay that the half-range due comparison can still order.
   localparam logic [TIME_W-1:0] DLY_MAX = TIME_W'((2 ** (TIME_W - 1)) - 1);

   // One in-flight sample plus the time at which it must be released.
   typedef struct packed {
      logic [SAMP_W-1:0] data;
      logic [TIME_W-1:0] due;
   } entry_t;

   // True when now has reached or passed due, modulo 2^TIME_W.
   function automatic logic due_reached(input logic [TIME_W-1:0] now,
                                        input logic [TIME_W-1:0] due);
      logic [TIME_W-1:0] diff;
      diff = now - due;
      return ~diff[TIME_W-1];
   endfunction

   // Zero becomes one cycle; anything past the ordering window is clamped.
   function automatic logic [TIME_W-1:0] clamp_dly(input logic [TIME_W-1:0] dly);
      logic [TIME_W-1:0] eff;
      if (dly == '0)
         eff = TIME_W'(1);
      else if (dly > DLY_MAX)
         eff = DLY_MAX;
      else
         eff = dly;
      return eff;
   endfunction

endpackage

// File: rtl/dly_chan.sv
// One output channel: an in-order FIFO of pending samples and the logic that
// releases the head once its due time has been reached.
module dly_chan
   import dly_sched_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [TIME_W-1:0] now,
   input  logic              push,
   input  entry_t            push_entry,
   input  logic              clr_ovf,
   output logic [SAMP_W-1:0] out_data,
   output logic              upd,
   output logic              ovf
);

   localparam int AW = $clog2(DEPTH);

   entry_t          mem [DEPTH];
   logic [AW-1:0]   rd_ptr_reg;
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW:0]     count_reg;
   logic [SAMP_W-1:0] out_reg;
   logic            upd_reg;
   logic            ovf_reg;

   entry_t          head;
   logic            full;
   logic            pop;
   logic            push_ok;
   logic            drop;

   // Head inspection; a full FIFO still accepts a push when the head leaves.
   always_comb begin
      head    = mem[rd_ptr_reg];
      full    = (count_reg == (AW + 1)'(DEPTH));
      pop     = (count_reg != '0) && due_reached(now, head.due);
      push_ok = push && (!full || pop);
      drop    = push && !push_ok;
   end

   // Entry storage; contents are only meaningful behind the pointers, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_reg] <= push_entry;
   end

   // Pointers, occupancy, registered output, update pulse and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
         out_reg    <= '0;
         upd_reg    <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({push_ok, pop})
            2'b10:   count_reg <= count_reg + (AW + 1)'(1);
            2'b01:   count_reg <= count_reg - (AW + 1)'(1);
            default: count_reg <= count_reg;
         endcase
         if (pop)
            out_reg <= head.data;
         upd_reg <= pop;
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop)
            ovf_reg <= 1'b1;
         else if (clr_ovf)
            ovf_reg <= 1'b0;
      end
   end

   assign out_data = out_reg;
   assign upd      = upd_reg;
   assign ovf      = ovf_reg;

endmodule

// File: rtl/dly_sched.sv
// Transport-delay scheduler: a free-running time base and two independent
// delay channels fed from a single capture strobe.
module dly_sched
   import dly_sched_pkg::*;
#(
   parameter int WIDTH = SAMP_W,
   parameter int DEPTH = 4,
   parameter int TW    = TIME_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             samp_valid,
   input  logic [WIDTH-1:0] samp_data,
   input  logic [TW-1:0]    dly_b,
   input  logic [TW-1:0]    dly_c,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] b_out,
   output logic [WIDTH-1:0] c_out,
   output logic             b_upd,
   output logic             c_upd,
   output logic             b_ovf,
   output logic             c_ovf,
   output logic [TW-1:0]    now
);

   logic [TW-1:0]    now_reg;
   logic [TW-1:0]    dly_arr [2];
   logic [WIDTH-1:0] out_arr [2];
   logic             upd_arr [2];
   logic             ovf_arr [2];

   // Free-running time base, wraps modulo 2^TW.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         now_reg <= '0;
      else
         now_reg <= now_reg + TW'(1);
   end

   assign dly_arr[0] = dly_b;
   assign dly_arr[1] = dly_c;

   for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      entry_t new_entry;

      // Due time uses the pre-edge time plus the effective delay.
      always_comb begin
         new_entry.data = samp_data;
         new_entry.due  = now_reg + clamp_dly(dly_arr[gi]);
      end

      dly_chan #(.DEPTH(DEPTH)) u_chan (
         .clk        (clk),
         .rst_n      (rst_n),
         .now        (now_reg),
         .push       (samp_valid),
         .push_entry (new_entry),
         .clr_ovf    (clr_ovf),
         .out_data   (out_arr[gi]),
         .upd        (upd_arr[gi]),
         .ovf        (ovf_arr[gi])
      );
   end

   assign b_out = out_arr[0];
   assign c_out = out_arr[1];
   assign b_upd = upd_arr[0];
   assign c_upd = upd_arr[1];
   assign b_ovf = ovf_arr[0];
   assign c_ovf = ovf_arr[1];
   assign now   = now_reg;

endmodule

// File: tb/tb_dly_sched.sv
// Scoreboard bench for dly_sched: the driver queues the expected release time
// and data per channel, the monitor pops and compares on every update pulse.
module tb_dly_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       samp_valid = 1'b0;
   logic [1:0] samp_data = '0;
   logic [7:0] dly_b = '0;
   logic [7:0] dly_c = '0;
   logic       clr_ovf = 1'b0;
   logic [1:0] b_out, c_out;
   logic       b_upd, c_upd, b_ovf, c_ovf;
   logic [7:0] now;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] t;
      logic [1:0] d;
   } exp_t;

   exp_t qb[$];
   exp_t qc[$];
   logic [7:0] tcnt;

   dly_sched #(.WIDTH(2), .DEPTH(4), .TW(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .samp_valid (samp_valid),
      .samp_data  (samp_data),
      .dly_b      (dly_b),
      .dly_c      (dly_c),
      .clr_ovf    (clr_ovf),
      .b_out      (b_out),
      .c_out      (c_out),
      .b_upd      (b_upd),
      .c_upd      (c_upd),
      .b_ovf      (b_ovf),
      .c_ovf      (c_ovf),
      .now        (now)
   );

   always #5 clk = ~clk;

   // Bench time reference: value that now held before the most recent edge + 1.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tcnt <= 8'd0;
      else
         tcnt <= tcnt + 8'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", name, act, req, tcnt);
      end else begin
         $display("ok   %s: 0x%0h (t=%0d)", name, act, tcnt);
      end
   endtask

   // Monitor: each update pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (b_upd) begin
            if (qb.size() == 0) begin
               chk("b_unexpected_upd", {30'd0, b_out}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = qb.pop_front();
               chk("b_release{t,data}", {22'd0, tcnt - 8'd1, b_out}, {22'd0, e.t, e.d});
            end
         end
         if (c_upd) begin
            if (qc.size() == 0) begin
               chk("c_unexpected_upd", {30'd0, c_out}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = qc.pop_front();
               chk("c_release{t,data}", {22'd0, tcnt - 8'd1, c_out}, {22'd0, e.t, e.d});
            end
         end
      end
   end

   function automatic logic [7:0] eff_dly(input logic [7:0] d);
      if (d == 8'd0)
         return 8'd1;
      else if (d > 8'd127)
         return 8'd127;
      else
         return d;
   endfunction

   // Called at a negedge; drives one capture cycle and returns at the next negedge.
   task automatic capture(input logic [1:0] data, input logic [7:0] db, input logic [7:0] dc,
                          input bit exp_b, input bit exp_c);
      exp_t e;
      samp_valid = 1'b1;
      samp_data  = data;
      dly_b      = db;
      dly_c      = dc;
      e.d = data;
      if (exp_b) begin
         e.t = tcnt + eff_dly(db);
         qb.push_back(e);
      end
      if (exp_c) begin
         e.t = tcnt + eff_dly(dc);
         qc.push_back(e);
      end
      @(negedge clk);
      samp_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((qb.size() != 0 || qc.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_drained"}, 32'(qb.size() + qc.size()), 32'd0);
   endtask

   task automatic wait_time(input logic [7:0] t);
      int n;
      n = 0;
      while (tcnt != t && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("wait_time_reached", {24'd0, tcnt}, {24'd0, t});
   endtask

   initial begin
      // Reset state.
      #12;
      chk("reset_now",   {24'd0, now}, 32'd0);
      chk("reset_b_out", {30'd0, b_out}, 32'd0);
      chk("reset_c_out", {30'd0, c_out}, 32'd0);
      chk("reset_upd",   {30'd0, b_upd, c_upd}, 32'd0);
      chk("reset_ovf",   {30'd0, b_ovf, c_ovf}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic latency: B loads 01@8, 10@9; C loads 01@13, 10@14.
      wait_time(8'd5);
      capture(2'b01, 8'd3, 8'd8, 1'b1, 1'b1);
      capture(2'b10, 8'd3, 8'd8, 1'b1, 1'b1);
      drain("basic", 40);
      idle(2);

      // Zero delay means one cycle; 200 is clamped to 127.
      capture(2'b11, 8'd0, 8'd200, 1'b1, 1'b1);
      drain("zero_clamp", 200);
      idle(2);

      // Overflow: six captures into a depth-4 channel B, last two dropped.
      // The clear on the sixth capture collides with a drop, so the flag stays set.
      capture(2'b00, 8'd10, 8'd1, 1'b1, 1'b1);
      capture(2'b01, 8'd10, 8'd1, 1'b1, 1'b1);
      capture(2'b10, 8'd10, 8'd1, 1'b1, 1'b1);
      capture(2'b11, 8'd10, 8'd1, 1'b1, 1'b1);
      capture(2'b00, 8'd10, 8'd1, 1'b0, 1'b1);
      clr_ovf = 1'b1;
      capture(2'b01, 8'd10, 8'd1, 1'b0, 1'b1);
      clr_ovf = 1'b0;
      chk("ovf_b_set_over_clear", {31'd0, b_ovf}, 32'd1);
      chk("ovf_c_clear",          {31'd0, c_ovf}, 32'd0);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      chk("ovf_b_cleared", {31'd0, b_ovf}, 32'd0);
      drain("overflow", 40);
      idle(2);

      // Full FIFO with simultaneous pop and push: delay 4, depth 4, no drops.
      for (int i = 0; i < 8; i++)
         capture(2'(i), 8'd4, 8'd4, 1'b1, 1'b1);
      drain("full_pop_push", 40);
      chk("full_pop_push_no_ovf", {30'd0, b_ovf, c_ovf}, 32'd0);

      // Ordering: a short delay queued behind a long one releases right after it.
      idle(2);
      begin
         exp_t e;
         logic [7:0] t0;
         t0 = tcnt;
         capture(2'b10, 8'd9, 8'd1, 1'b1, 1'b1);
         // Second entry is due at t0+3 but blocks behind the head until t0+9,
         // then leaves on the following cycle.
         samp_valid = 1'b1;
         samp_data  = 2'b01;
         dly_b      = 8'd2;
         dly_c      = 8'd1;
         e.d = 2'b01;
         e.t = t0 + 8'd10;
         qb.push_back(e);
         e.t = tcnt + 8'd1;
         qc.push_back(e);
         @(negedge clk);
         samp_valid = 1'b0;
      end
      drain("order", 40);

      // Wrap: capture at 250 with delay 10 releases at 4.
      wait_time(8'd250);
      capture(2'b11, 8'd10, 8'd10, 1'b1, 1'b1);
      drain("wrap", 40);
      idle(2);

      // Reset mid-flight: three pending entries must vanish with no release.
      capture(2'b01, 8'd20, 8'd20, 1'b0, 1'b0);
      capture(2'b10, 8'd20, 8'd20, 1'b0, 1'b0);
      capture(2'b11, 8'd20, 8'd20, 1'b0, 1'b0);
      idle(3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_now",   {24'd0, now}, 32'd0);
      chk("midrst_outs",  {28'd0, b_out, c_out}, 32'd0);
      chk("midrst_upd",   {30'd0, b_upd, c_upd}, 32'd0);
      chk("midrst_ovf",   {30'd0, b_ovf, c_ovf}, 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(25);
      chk("midrst_no_pending", 32'(qb.size() + qc.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
